dma_bus_arbiter: RTL and testbench
==================================

Name: dma_bus_arbiter

Overview:
Parametrised CPU/DMA bus arbiter and RAM mux, the next generation of the single-channel 4-cycle arbiter in the pdp11 bus interface. It arbitrates NCHAN DMA masters against the CPU with round-robin fairness and a configurable burst length. It drives the shared RAM port from either the CPU or the granted DMA channel. It sits between the CPU bus, the iopage DMA devices and the RAM controller.

Parameters:
NCHAN, 4, number of DMA request channels (1..8)
BURST, 4, maximum consecutive DMA cycles per grant (1..15)
AW, 22, address width
DW, 16, data width

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cpu_addr  input  AW  CPU bus address
cpu_data_in  input  DW  CPU write data
cpu_rd  input  1  CPU RAM read strobe (already qualified by RAM decode)
cpu_wr  input  1  CPU RAM write strobe (already qualified by RAM decode)
cpu_byte_op  input  1  CPU byte access
cpu_arbitrate  input  1  CPU permits bus handover this cycle
cpu_ack  output  1  CPU owns the bus
dma_req  input  NCHAN  per-channel request
dma_ack  output  NCHAN  one-hot per-channel grant
dma_addr  input  NCHAN*AW  packed channel addresses; channel i is at [i*AW +: AW]
dma_data_out  input  NCHAN*DW  packed channel write data
dma_rd  input  NCHAN  per-channel read strobe
dma_wr  input  NCHAN  per-channel write strobe
dma_data_in  output  DW  RAM read data, broadcast to all channels
ram_addr  output  AW  RAM address
ram_data_out  output  DW  RAM write data
ram_data_in  input  DW  RAM read data
ram_rd  output  1  RAM read
ram_wr  output  1  RAM write
ram_byte_op  output  1  RAM byte access
grant_chan  output  3  index of the granted channel (0 when the CPU owns the bus)

Behaviour:
- States: CPU (bus owned by the CPU) and DMA (bus owned by channel grant_chan). Registered state, burst counter cnt (4 bits), last-served pointer last (3 bits).
- Reset values: state=CPU, cnt=0, last=NCHAN-1, grant_chan=0. Outputs at reset: cpu_ack=1, dma_ack=0.
- CPU->DMA transition: happens when |dma_req && cpu_arbitrate are both sampled at edge n.
  - The winner is the first requesting channel scanning last+1, last+2, ... with modulo-NCHAN wrap.
  - From cycle n+1: dma_ack[winner]=1, cpu_ack=0, grant_chan=winner, cnt=0, last=winner.
- DMA state: each cycle, cnt increments.
  - Return to CPU when cnt==BURST-1, or when dma_req[grant_chan]==0 at the sampling edge.
  - A grant therefore lasts 1..BURST cycles.
- After any DMA burst the bus always returns to the CPU for at least one cycle. No back-to-back bursts, even if other channels are requesting.
- The CPU never loses the bus unless cpu_arbitrate is asserted. Requests without arbitrate are held pending indefinitely.
- Mux (combinational from registered state):
  - CPU state: ram_* follow the cpu_* inputs.
  - DMA state: ram_addr, ram_data_out, ram_rd and ram_wr take the granted channel's slice; ram_byte_op=0.
  - ram_rd and ram_wr are forced 0 if the selected source asserts both in the same cycle.
- dma_data_in=ram_data_in at all times. Channels qualify the data with their own dma_ack.
- Non-granted dma_rd/dma_wr are ignored.
- NCHAN=1 degenerates to the legacy behaviour: a BURST-cycle grant, with the pointer fixed at 0.
- Reset mid-burst: next cycle state=CPU, dma_ack=0, last=NCHAN-1. The interrupted transfer is lost and the channel must re-request.
- A request dropped and re-raised during its own grant ends the grant at that edge; it competes again after the CPU cycle.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: the winner is the lowest-index requesting channel; last is still updated but not used for selection.
- Undefined: round-robin as above.
- Burst length, CPU return cycle and mux behaviour are identical in both modes.

Test Plan:
- Reset, then idle: cpu_ack=1, dma_ack=0, grant_chan=0; cpu_addr=0o1000 with cpu_wr -> ram_addr=0o1000, ram_wr=1.
- dma_req=0001 with cpu_arbitrate=1, held continuously -> dma_ack=0001 for exactly 4 cycles, then cpu_ack=1 for 1 cycle, then regrant.
- dma_req=1111 held, cpu_arbitrate=1 -> grants in channel order 0,1,2,3,0; each grant is 4 cycles, separated by single CPU cycles.
- Channel 2 granted, drops its request after 2 cycles -> dma_ack falls at the next edge, cpu_ack=1; ram_addr mirrored channel 2's address during the grant.
- dma_req=0100 with cpu_arbitrate=0 for 10 cycles -> no grant; arbitrate raised -> dma_ack=0100 next cycle.
- Reset asserted in the 2nd cycle of a burst -> cpu_ack=1 the next cycle; then dma_req=1111 -> channel 0 is granted first.

Source files
------------

// File: rtl/dma_bus_arbiter_if.sv
// Bus bundle between the CPU, the DMA channels, the RAM port and dma_bus_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dma_bus_arbiter_if #(
  parameter int NCHAN = 4,
  parameter int AW    = 22,
  parameter int DW    = 16
);
  logic [AW-1:0]       cpu_addr;
  logic [DW-1:0]       cpu_data_in;
  logic                cpu_rd;
  logic                cpu_wr;
  logic                cpu_byte_op;
  logic                cpu_arbitrate;
  logic                cpu_ack;
  logic [NCHAN-1:0]    dma_req;
  logic [NCHAN-1:0]    dma_ack;
  logic [NCHAN*AW-1:0] dma_addr;
  logic [NCHAN*DW-1:0] dma_data_out;
  logic [NCHAN-1:0]    dma_rd;
  logic [NCHAN-1:0]    dma_wr;
  logic [DW-1:0]       dma_data_in;
  logic [AW-1:0]       ram_addr;
  logic [DW-1:0]       ram_data_out;
  logic [DW-1:0]       ram_data_in;
  logic                ram_rd;
  logic                ram_wr;
  logic                ram_byte_op;
  logic [2:0]          grant_chan;

  modport slave (
    input  cpu_addr, cpu_data_in, cpu_rd, cpu_wr, cpu_byte_op, cpu_arbitrate,
    input  dma_req, dma_addr, dma_data_out, dma_rd, dma_wr, ram_data_in,
    output cpu_ack, dma_ack, dma_data_in, ram_addr, ram_data_out,
    output ram_rd, ram_wr, ram_byte_op, grant_chan
  );

  modport master (
    output cpu_addr, cpu_data_in, cpu_rd, cpu_wr, cpu_byte_op, cpu_arbitrate,
    output dma_req, dma_addr, dma_data_out, dma_rd, dma_wr, ram_data_in,
    input  cpu_ack, dma_ack, dma_data_in, ram_addr, ram_data_out,
    input  ram_rd, ram_wr, ram_byte_op, grant_chan
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// CPU / NCHAN-channel DMA bus arbiter with bounded bursts and a RAM port mux.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module dma_bus_arbiter #(
  parameter int NCHAN = 4,
  parameter int BURST = 4,
  parameter int AW    = 22,
  parameter int DW    = 16
) (
  input logic             clk,
  input logic             reset,
  dma_bus_arbiter_if.slave bus
);
  typedef enum logic {S_CPU, S_DMA} state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] last, last_n, grant, grant_n, win, cand;

  // Channels padded to 8 so a 3-bit index always selects in range.
  logic [7:0]         req8, rd8, wr8;
  logic [7:0][AW-1:0] addr8;
  logic [7:0][DW-1:0] data8;

  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_data;
  logic          src_rd, src_wr, src_byte;

  for (genvar i = 0; i < 8; i++) begin : g_chan
    if (i < NCHAN) begin : g_live
      assign req8[i]  = bus.dma_req[i];
      assign rd8[i]   = bus.dma_rd[i];
      assign wr8[i]   = bus.dma_wr[i];
      assign addr8[i] = bus.dma_addr[i*AW +: AW];
      assign data8[i] = bus.dma_data_out[i*DW +: DW];
      assign bus.dma_ack[i] = (state == S_DMA) && (grant == 3'(i));
    end else begin : g_pad
      assign req8[i]  = 1'b0;
      assign rd8[i]   = 1'b0;
      assign wr8[i]   = 1'b0;
      assign addr8[i] = '0;
      assign data8[i] = '0;
    end
  end

  always_comb begin
    win  = '0;
    cand = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = NCHAN - 1; i >= 0; i--) begin
      cand = 3'(i);
      if (req8[cand]) win = cand;
    end
`else
    // Scan from farthest to nearest so the channel right after last wins.
    for (int k = NCHAN; k >= 1; k--) begin
      cand = 3'((int'(last) + k) % NCHAN);
      if (req8[cand]) win = cand;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_CPU;
      cnt   <= '0;
      last  <= 3'(NCHAN - 1);
      grant <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      last  <= last_n;
      grant <= grant_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    grant_n = grant;
    case (state)
      S_CPU: begin
        if ((|req8) && bus.cpu_arbitrate) begin
          state_n = S_DMA;
          cnt_n   = '0;
          last_n  = win;
          grant_n = win;
        end
      end
      S_DMA: begin
        cnt_n = cnt + 4'd1;
        // Always hand back to the CPU: no back-to-back bursts.
        if (cnt == 4'(BURST - 1) || !req8[grant]) begin
          state_n = S_CPU;
          cnt_n   = '0;
          grant_n = '0;
        end
      end
      default: state_n = S_CPU;
    endcase
  end

  always_comb begin
    if (state == S_DMA) begin
      src_addr = addr8[grant];
      src_data = data8[grant];
      src_rd   = rd8[grant];
      src_wr   = wr8[grant];
      src_byte = 1'b0;
    end else begin
      src_addr = bus.cpu_addr;
      src_data = bus.cpu_data_in;
      src_rd   = bus.cpu_rd;
      src_wr   = bus.cpu_wr;
      src_byte = bus.cpu_byte_op;
    end
  end

  assign bus.ram_addr     = src_addr;
  assign bus.ram_data_out = src_data;
  assign bus.ram_rd       = src_rd & ~src_wr;
  assign bus.ram_wr       = src_wr & ~src_rd;
  assign bus.ram_byte_op  = src_byte;
  assign bus.dma_data_in  = bus.ram_data_in;
  assign bus.cpu_ack      = (state == S_CPU);
  assign bus.grant_chan   = grant;
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed scenarios then random traffic for dma_bus_arbiter, checked against
// an ownership-level reference model (owner, cycles used, last served).
module tb_dma_bus_arbiter;
  localparam int NCHAN = 4;
  localparam int BURST = 4;
  localparam int AW    = 22;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dma_bus_arbiter_if #(.NCHAN(NCHAN), .AW(AW), .DW(DW)) bus ();

  dma_bus_arbiter #(.NCHAN(NCHAN), .BURST(BURST), .AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  // Model: owner -1 means CPU, otherwise the channel holding the bus.
  int owner = -1;
  int used  = 0;
  int lastp = NCHAN - 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NCHAN-1:0] req, input int lp);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NCHAN; i++) if (req[i]) return i;
`else
    for (int k = 1; k <= NCHAN; k++) if (req[(lp + k) % NCHAN]) return (lp + k) % NCHAN;
`endif
    return -1;
  endfunction

  task automatic model_step();
    if (reset) begin
      owner = -1; used = 0; lastp = NCHAN - 1;
    end else if (owner < 0) begin
      if (bus.dma_req != 0 && bus.cpu_arbitrate) begin
        owner = pick(bus.dma_req, lastp);
        lastp = owner;
        used  = 1;
      end
    end else if (used == BURST || !bus.dma_req[owner]) begin
      owner = -1; used = 0;
    end else begin
      used++;
    end
  endtask

  task automatic check_ctl();
    chk("cpu_ack", bus.cpu_ack, owner < 0);
    chk("dma_ack", bus.dma_ack, owner < 0 ? 0 : (1 << owner));
    chk("grant_chan", bus.grant_chan, owner < 0 ? 0 : owner);
  endtask

  task automatic check_mux();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic rd, wr, by;
    if (owner < 0) begin
      a = bus.cpu_addr; d = bus.cpu_data_in; rd = bus.cpu_rd; wr = bus.cpu_wr; by = bus.cpu_byte_op;
    end else begin
      a = bus.dma_addr[owner*AW +: AW]; d = bus.dma_data_out[owner*DW +: DW];
      rd = bus.dma_rd[owner]; wr = bus.dma_wr[owner]; by = 1'b0;
    end
    chk("ram_addr", bus.ram_addr, a);
    chk("ram_data_out", bus.ram_data_out, d);
    chk("ram_rd", bus.ram_rd, rd && !wr);
    chk("ram_wr", bus.ram_wr, wr && !rd);
    chk("ram_byte_op", bus.ram_byte_op, by);
    chk("dma_data_in", bus.dma_data_in, bus.ram_data_in);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_ctl();
  endtask

  task automatic settle();
    #1;
    check_mux();
  endtask

  task automatic rand_data();
    bus.cpu_addr    = AW'($urandom);
    bus.cpu_data_in = DW'($urandom);
    bus.cpu_rd      = 1'($urandom);
    bus.cpu_wr      = 1'($urandom);
    bus.cpu_byte_op = 1'($urandom);
    bus.dma_rd      = NCHAN'($urandom);
    bus.dma_wr      = NCHAN'($urandom);
    bus.ram_data_in = DW'($urandom);
    for (int i = 0; i < NCHAN; i++) begin
      bus.dma_addr[i*AW +: AW]     = AW'($urandom);
      bus.dma_data_out[i*DW +: DW] = DW'($urandom);
    end
  endtask

  initial begin
    logic [9:0]  ack_seq;
    logic [14:0] order;
    int          starts;
    int          idle_acks;
    logic        prev_cpu;

    reset = 1'b1;
    bus.cpu_arbitrate = 1'b0;
    bus.dma_req = '0;
    rand_data();
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    // Idle after reset: CPU owns the bus and passes its strobes through.
    bus.cpu_addr = 22'o1000;
    bus.cpu_wr   = 1'b1;
    tick();
    settle();
    chk("s1 cpu_ack", bus.cpu_ack, 1'b1);
    chk("s1 dma_ack", bus.dma_ack, 4'b0000);
    chk("s1 ram_addr", bus.ram_addr, 22'o1000);
    chk("s1 ram_wr", bus.ram_wr, 1'b1);

    // Single channel held: 4-cycle grants separated by one CPU cycle.
    bus.cpu_wr = 1'b0;
    bus.dma_req = 4'b0001;
    bus.cpu_arbitrate = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); settle();
      ack_seq[i] = bus.dma_ack[0];
    end
    chk("s2 burst pattern", ack_seq, 10'b0111101111);

    // All channels held: round-robin order 0,1,2,3,0 from reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.dma_req = 4'b1111;
    order = '0; starts = 0; prev_cpu = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick(); settle();
      if (prev_cpu && !bus.cpu_ack) begin
        order = {order[11:0], bus.grant_chan};
        starts++;
      end
      prev_cpu = bus.cpu_ack;
    end
    chk("s3 grant starts", starts, 5);
    chk("s3 grant order", order, {3'd0, 3'd1, 3'd2, 3'd3, 3'd0});

    // Channel 2 drops its request after two granted cycles.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.dma_req = 4'b0100;
    bus.dma_addr[2*AW +: AW] = 22'h2abcd;
    tick(); settle();
    chk("s4 ack c1", bus.dma_ack, 4'b0100);
    chk("s4 addr c1", bus.ram_addr, 22'h2abcd);
    tick(); settle();
    chk("s4 addr c2", bus.ram_addr, 22'h2abcd);
    bus.dma_req = 4'b0000;
    tick(); settle();
    chk("s4 cpu back", bus.cpu_ack, 1'b1);

    // Pending request without arbitrate is never granted.
    bus.dma_req = 4'b0100;
    bus.cpu_arbitrate = 1'b0;
    idle_acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); settle();
      if (bus.dma_ack != 0) idle_acks++;
    end
    chk("s5 no grant", idle_acks, 0);
    bus.cpu_arbitrate = 1'b1;
    tick(); settle();
    chk("s5 grant c2", bus.dma_ack, 4'b0100);

    // Reset in the second burst cycle, then round-robin restarts at 0.
    tick();
    reset = 1'b1;
    tick(); settle();
    chk("s6 cpu_ack", bus.cpu_ack, 1'b1);
    chk("s6 dma_ack", bus.dma_ack, 4'b0000);
    reset = 1'b0;
    bus.dma_req = 4'b1111;
    tick(); settle();
    chk("s6 first grant", bus.grant_chan, 3'd0);
    chk("s6 first ack", bus.dma_ack, 4'b0001);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      tick();
      rand_data();
      if ($urandom_range(2) == 0) bus.dma_req = NCHAN'($urandom);
      bus.cpu_arbitrate = ($urandom_range(3) != 0);
      reset = ($urandom_range(49) == 0);
      settle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
